// File: rtl/mem_bus_if.sv
// mem_bus_if: request/grant memory bus between a requester (master) and a responder (slave).
interface mem_bus_if #(
    parameter int MEM_ADDR_W = 64,
    parameter int MEM_DATA_W = 64,
    parameter int MEM_STRB_W = 8
);
    logic                  mem_req;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic                  mem_wen;
    logic [MEM_STRB_W-1:0] mem_strb;
    logic [MEM_DATA_W-1:0] mem_wdata;
    logic                  mem_gnt;
    logic                  mem_err;
    logic [MEM_DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_addr, mem_wen, mem_strb, mem_wdata,
        input  mem_gnt, mem_err, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr, mem_wen, mem_strb, mem_wdata,
        output mem_gnt, mem_err, mem_rdata
    );
endinterface

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: single-cycle memory responder with bounded pseudo-random grant stalls.
module mem_bus_responder #(
    parameter int          MEM_ADDR_W = 64,
    parameter int          MEM_DATA_W = 64,
    parameter int          MEM_STRB_W = 8,
    parameter int          DEPTH_LOG2 = 8,
    parameter int          MAX_STALL  = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       g_clk,
    input  logic       g_resetn,
    input  logic       stall_en,
    mem_bus_if.slave   bus,
    output logic [2:0] stall_cnt
);
    logic [15:0]           lfsr;
    logic                  stall;
    logic                  accept;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic [MEM_DATA_W-1:0] store [1<<DEPTH_LOG2];
    logic                  unused_lsb;

    assign idx        = bus.mem_addr[DEPTH_LOG2+2:3];
    assign in_range   = bus.mem_addr[MEM_ADDR_W-1:DEPTH_LOG2+3] == '0;
    assign unused_lsb = ^bus.mem_addr[2:0];
    // once the stall count saturates the stall is forced off, so the count can never pass MAX_STALL
    assign stall       = stall_en && stall_cnt != 3'(MAX_STALL) && lfsr[0];
    assign bus.mem_gnt = bus.mem_req && g_resetn && !stall;
    assign accept      = bus.mem_req && bus.mem_gnt;

    always_ff @(posedge g_clk or negedge g_resetn)
        if (!g_resetn) begin
            lfsr          <= LFSR_SEED;
            stall_cnt     <= '0;
            bus.mem_err   <= 1'b0;
            bus.mem_rdata <= '0;
        end else begin
            lfsr          <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            stall_cnt     <= (bus.mem_req && !accept) ? stall_cnt + 3'd1 : 3'd0;
            bus.mem_err   <= accept && !in_range;
            bus.mem_rdata <= (accept && in_range && !bus.mem_wen) ? store[idx] : '0;
        end

    // backing store is deliberately left out of reset
    always_ff @(posedge g_clk)
        for (int i = 0; i < MEM_STRB_W; i++)
            if (accept && in_range && bus.mem_wen && bus.mem_strb[i])
                store[idx][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: random and directed stimulus checked against a transaction-level model.
module tb_mem_bus_responder;
    logic g_clk = 1'b0;
    logic g_resetn = 1'b0;
    logic stall_en = 1'b0;
    logic [2:0] stall_cnt;
    int n_chk = 0;
    int n_fail = 0;

    logic [63:0] mem_m [256];
    logic [15:0] lfsr_m;
    int          wait_m;
    logic        exp_err;
    logic [63:0] exp_rdata;

    mem_bus_if bus ();

    mem_bus_responder dut (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .stall_en  (stall_en),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    always #5 g_clk = ~g_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic req, input logic wen, input logic [63:0] addr,
                         input logic [7:0] strb, input logic [63:0] wdata);
        bus.mem_req   = req;
        bus.mem_wen   = wen;
        bus.mem_addr  = addr;
        bus.mem_strb  = strb;
        bus.mem_wdata = wdata;
    endtask

    task automatic model_reset();
        exp_err   = 1'b0;
        exp_rdata = '0;
        wait_m    = 0;
        lfsr_m    = 16'hACE1;
    endtask

    // one bus cycle: check outputs mid-cycle, then advance the model across the clock edge
    task automatic step(output logic g);
        logic exp_gnt;
        logic in_rng;
        logic [7:0] idx;
        @(negedge g_clk);
        exp_gnt = bus.mem_req && !(stall_en && wait_m != 4 && lfsr_m[0]);
        check("gnt", bus.mem_gnt, exp_gnt);
        check("err", bus.mem_err, exp_err);
        check("rdata", bus.mem_rdata, exp_rdata);
        check("stall_cnt", stall_cnt, 64'(wait_m));
        g = bus.mem_gnt;
        in_rng = bus.mem_addr[63:11] == '0;
        idx = bus.mem_addr[10:3];
        exp_err = exp_gnt && !in_rng;
        exp_rdata = (exp_gnt && in_rng && !bus.mem_wen) ? mem_m[idx] : 64'd0;
        if (exp_gnt && in_rng && bus.mem_wen)
            for (int b = 0; b < 8; b++)
                if (bus.mem_strb[b]) mem_m[idx][8*b +: 8] = bus.mem_wdata[8*b +: 8];
        wait_m = (bus.mem_req && !exp_gnt) ? wait_m + 1 : 0;
        lfsr_m = {lfsr_m[14:0], ^(lfsr_m & 16'hB400)};
        @(posedge g_clk);
        #1;
    endtask

    task automatic op(input logic wen, input logic [63:0] addr, input logic [7:0] strb,
                      input logic [63:0] wdata);
        logic g;
        int waited;
        drive(1'b1, wen, addr, strb, wdata);
        waited = 0;
        step(g);
        while (!g && waited < 8) begin
            waited++;
            step(g);
        end
        check("wait_bound", 64'(waited <= 4), 64'd1);
    endtask

    task automatic idle();
        logic g;
        drive(1'b0, 1'b0, 64'd0, 8'd0, 64'd0);
        step(g);
    endtask

    initial begin
        drive(1'b1, 1'b0, 64'h10, 8'h00, 64'd0);
        #3;
        check("rst_gnt", bus.mem_gnt, 64'd0);
        check("rst_err", bus.mem_err, 64'd0);
        check("rst_rdata", bus.mem_rdata, 64'd0);
        check("rst_stall_cnt", stall_cnt, 64'd0);
        repeat (2) @(posedge g_clk);
        #1;
        model_reset();
        g_resetn = 1'b1;
        // first cycle after release: request already pending and must be granted
        op(1'b0, 64'h10, 8'h00, 64'd0);
        for (int w = 0; w < 16; w++) op(1'b1, 64'(w) << 3, 8'hFF, {$urandom, $urandom});
        op(1'b1, 64'h10, 8'hFF, 64'h1122334455667788);
        op(1'b0, 64'h10, 8'h00, 64'd0);
        check("s035_rdata", bus.mem_rdata, 64'h1122334455667788);
        check("s035_err", bus.mem_err, 64'd0);
        op(1'b1, 64'h10, 8'h0F, 64'hFFFFFFFFFFFFFFFF);
        op(1'b0, 64'h10, 8'h00, 64'd0);
        check("s036_rdata", bus.mem_rdata, 64'h11223344FFFFFFFF);
        op(1'b0, 64'h800, 8'h00, 64'd0);
        check("s037_err", bus.mem_err, 64'd1);
        check("s037_rdata", bus.mem_rdata, 64'd0);
        op(1'b1, 64'h800, 8'hFF, 64'hDEADBEEFDEADBEEF);
        op(1'b0, 64'h0, 8'h00, 64'd0);
        op(1'b1, 64'h18, 8'h00, 64'hA5A5A5A5A5A5A5A5);
        op(1'b0, 64'h18, 8'h00, 64'd0);
        op(1'b0, 64'h0, 8'h00, 64'd0);
        op(1'b0, 64'h8, 8'h00, 64'd0);
        op(1'b0, 64'h10, 8'h00, 64'd0);
        idle();
        for (int n = 0; n < 250; n++) begin
            logic [63:0] a;
            stall_en = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 4) == 0) begin
                idle();
                continue;
            end
            a = (64'($urandom_range(0, 15)) << 3) | 64'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = a | (64'd1 << $urandom_range(11, 63));
            op(1'($urandom_range(0, 1)), a, ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom),
               {$urandom, $urandom});
        end
        stall_en = 1'b0;
        idle();
        op(1'b0, 64'h10, 8'h00, 64'd0);
        g_resetn = 1'b0;
        #1;
        check("s039_err", bus.mem_err, 64'd0);
        check("s039_rdata", bus.mem_rdata, 64'd0);
        check("s039_gnt", bus.mem_gnt, 64'd0);
        check("s039_stall_cnt", stall_cnt, 64'd0);
        repeat (2) @(posedge g_clk);
        #1;
        model_reset();
        drive(1'b0, 1'b0, 64'd0, 8'd0, 64'd0);
        g_resetn = 1'b1;
        idle();
        op(1'b0, 64'h8, 8'h00, 64'd0);
        idle();
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_bus_responder.md
MEM_BUS_RESPONDER -- requirements
Module: mem_bus_responder

Interface
REQ-001 The block SHALL have parameter MEM_ADDR_W, default 64, meaning request address width.
REQ-002 The block SHALL have parameter MEM_DATA_W, default 64, meaning data bus width.
REQ-003 The block SHALL have parameter MEM_STRB_W, default 8, meaning byte-strobe width (MEM_DATA_W/8).
REQ-004 The block SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of backing-store depth in MEM_DATA_W words.
REQ-005 The block SHALL have parameter MAX_STALL, default 4, meaning maximum consecutive cycles a request is left ungranted.
REQ-006 The block SHALL have parameter LFSR_SEED, default 16'hACE1, meaning nonzero stall-generator reset value.
REQ-007 The block SHALL have port g_clk, input, 1, meaning the single clock; all state SHALL be on its rising edge.
REQ-008 The block SHALL have port g_resetn, input, 1, meaning reset, which is asynchronous and active-low.
REQ-009 The block SHALL have port stall_en, input, 1, meaning that 1 enables pseudo-random grant stalls.
REQ-010 The block SHALL have port mem_req, input, 1, meaning request valid, held by the requester until granted.
REQ-011 The block SHALL have port mem_addr, input, MEM_ADDR_W, meaning byte address.
REQ-012 The block SHALL have port mem_wen, input, 1, meaning write enable.
REQ-013 The block SHALL have port mem_strb, input, MEM_STRB_W, meaning write byte lanes.
REQ-014 The block SHALL have port mem_wdata, input, MEM_DATA_W, meaning write data.
REQ-015 The block SHALL have port mem_gnt, output, 1, meaning request accepted this cycle.
REQ-016 The block SHALL have port mem_err, output, 1, meaning response error, valid the cycle after accept.
REQ-017 The block SHALL have port mem_rdata, output, MEM_DATA_W, meaning read response data, valid the cycle after accept.
REQ-018 The block SHALL have port stall_cnt, output, 3, meaning current consecutive-stall count, for debug.

Function
REQ-019 An accept SHALL occur in a cycle where mem_req && mem_gnt, and mem_gnt SHALL be combinational: mem_req && g_resetn && !stall.
REQ-020 stall SHALL be 0 when stall_en==0 or stall_cnt==MAX_STALL, and SHALL equal lfsr[0] otherwise.
REQ-021 stall_cnt SHALL increment on mem_req && !mem_gnt, clear on accept or !mem_req, and never exceed MAX_STALL.
REQ-022 The LFSR SHALL be 16-bit Fibonacci with taps 16,14,13,11, shift left inserting the feedback bit at bit 0, and advance every cycle regardless of request activity.
REQ-023 Word index SHALL be mem_addr[DEPTH_LOG2+2:3]; an address SHALL be in range iff all of mem_addr[MEM_ADDR_W-1:DEPTH_LOG2+3] are 0.
REQ-024 An out-of-range accept SHALL set mem_err=1 and mem_rdata=0 in the next cycle, with no store update.
REQ-025 An in-range write accept SHALL update only the byte lanes with mem_strb[i]=1 at the clock edge, followed by mem_err=0 and mem_rdata=0 in the next cycle.
REQ-026 An in-range read accept SHALL return the stored word in mem_rdata with mem_err=0 in the next cycle, so read latency is 1 cycle after accept.
REQ-027 A read accepted the cycle after a write to the same word SHALL return the post-write value.
REQ-028 In cycles without a preceding accept, mem_err and mem_rdata SHALL be 0.
REQ-029 Back-to-back accepts SHALL be supported every cycle, with no bubble required.
REQ-030 A write with mem_strb==0 SHALL complete as a normal write response and SHALL leave the store unchanged.

Reset
REQ-031 While g_resetn==0, the block SHALL hold mem_gnt=0, mem_err=0, mem_rdata=0, stall_cnt=0, and lfsr=LFSR_SEED, applied asynchronously.
REQ-032 Backing-store contents SHALL NOT be reset.
REQ-033 A response pending when reset asserts SHALL be discarded.
REQ-034 The first accept SHALL be possible in the first cycle after deassertion.

Verification
REQ-035 Scenario: stall_en=0; write addr 0x10, strb 0xFF, data 0x1122334455667788; then read 0x10 -> gnt=1 in both request cycles; read response next cycle returns 0x1122334455667788 with err=0.
REQ-036 Scenario: write addr 0x10, strb 0x0F, data 0xFFFFFFFFFFFFFFFF over the prior value; read 0x10 -> returns 0x11223344FFFFFFFF.
REQ-037 Scenario: read 0x800 (DEPTH_LOG2=8) -> err=1 and rdata=0 one cycle after accept; a following write to 0x800 leaves word 0 unchanged.
REQ-038 Scenario: stall_en=1 with mem_req held for 20 requests -> no request waits more than 4 cycles, and stall_cnt never exceeds 4.
REQ-039 Scenario: g_resetn dropped mid-cycle between accept and response -> err and rdata go to 0 immediately, and no response appears after release.
REQ-040 Scenario: continuous reads to 0x0, 0x8, 0x10 with stall_en=0 -> three accepts in three consecutive cycles, with responses in order one cycle later.
